// File: rtl/exec_ctrl_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exec_ctrl_mem_pkg
// Description : Shared encodings for the execute/control/data-memory slice.
//               Holds the opcode/funct values, ALU operation codes, mux
//               select codes and the packed control bundle produced by the
//               instruction decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package exec_ctrl_mem_pkg;

    // Primary opcodes, instruction[31:26]
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_JAL   = 6'b000011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDIU = 6'b001001;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;
    localparam logic [5:0] c_OP_LUI   = 6'b001111;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;

    // R-type function codes, instruction[5:0]
    localparam logic [5:0] c_FN_JR    = 6'b001000;
    localparam logic [5:0] c_FN_ADDU  = 6'b100001;
    localparam logic [5:0] c_FN_SUBU  = 6'b100011;
    localparam logic [5:0] c_FN_AND   = 6'b100100;
    localparam logic [5:0] c_FN_OR    = 6'b100101;
    localparam logic [5:0] c_FN_SLT   = 6'b101010;

    // ALU operation codes
    localparam logic [2:0] c_ALU_ADD  = 3'b000;
    localparam logic [2:0] c_ALU_SUB  = 3'b001;
    localparam logic [2:0] c_ALU_AND  = 3'b010;
    localparam logic [2:0] c_ALU_OR   = 3'b011;
    localparam logic [2:0] c_ALU_SLT  = 3'b100;
    localparam logic [2:0] c_ALU_LUI  = 3'b101;
    localparam logic [2:0] c_ALU_XOR  = 3'b110;
    localparam logic [2:0] c_ALU_NOR  = 3'b111;

    // Destination register select
    localparam logic [1:0] c_RD_RT    = 2'b00;
    localparam logic [1:0] c_RD_RD    = 2'b01;
    localparam logic [1:0] c_RD_RA    = 2'b10;

    // ALU B source select
    localparam logic [1:0] c_SRC_REG  = 2'b00;
    localparam logic [1:0] c_SRC_ZIMM = 2'b01;
    localparam logic [1:0] c_SRC_SIMM = 2'b10;

    // Write-back source select
    localparam logic [1:0] c_M2R_ALU  = 2'b00;
    localparam logic [1:0] c_M2R_MEM  = 2'b01;
    localparam logic [1:0] c_M2R_PC4  = 2'b10;

    // Branch / jump kind
    localparam logic [1:0] c_BR_NONE  = 2'b00;
    localparam logic [1:0] c_BR_BEQ   = 2'b01;
    localparam logic [1:0] c_BR_JR    = 2'b10;
    localparam logic [1:0] c_BR_JUMP  = 2'b11;

    typedef struct packed {
        logic [1:0] reg_dst;
        logic [1:0] alu_src;
        logic [1:0] mem_to_reg;
        logic [1:0] branch;
        logic [2:0] alu_op;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       jump_en;
    } ctrl_t;

    localparam ctrl_t c_CTRL_NOP = '0;

    // Register-register arithmetic: all share the same routing, only the
    // ALU operation differs.
    function automatic ctrl_t rtype_ctrl(input logic [2:0] alu_op);
        ctrl_t v;
        v            = c_CTRL_NOP;
        v.reg_dst    = c_RD_RD;
        v.alu_src    = c_SRC_REG;
        v.mem_to_reg = c_M2R_ALU;
        v.branch     = c_BR_NONE;
        v.alu_op     = alu_op;
        v.reg_write  = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/exec_alu.sv
`default_nettype none
// ============================================================================
// Module      : exec_alu
// Description : Combinational 32-bit ALU with signed-overflow flag.
//   a, b    : operands
//   op      : operation code (add/sub/and/or/slt/lui/xor/nor)
//   result  : 32-bit result
//   over    : signed overflow, meaningful only for add and sub
// Revision    : 1.0 - initial release
// ============================================================================
module exec_alu
    import exec_ctrl_mem_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output logic [31:0] result,
    output logic        over
);

    logic [31:0] w_sum;
    logic [31:0] w_diff;

    assign w_sum  = a + b;
    assign w_diff = a - b;

    always_comb begin
        result = '0;
        over   = 1'b0;
        case (op)
            c_ALU_ADD: begin
                result = w_sum;
                // Same-sign operands producing an opposite-sign sum
                over   = (a[31] == b[31]) && (w_sum[31] != a[31]);
            end
            c_ALU_SUB: begin
                result = w_diff;
                // Opposite-sign operands producing a result whose sign
                // disagrees with the minuend
                over   = (a[31] != b[31]) && (w_diff[31] != a[31]);
            end
            c_ALU_AND: result = a & b;
            c_ALU_OR:  result = a | b;
            c_ALU_SLT: result = {31'd0, ($signed(a) < $signed(b))};
            c_ALU_LUI: result = {b[15:0], 16'd0};
            c_ALU_XOR: result = a ^ b;
            c_ALU_NOR: result = ~(a | b);
            default:   result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/exec_ctrl_mem.sv
`default_nettype none
// ============================================================================
// Module      : exec_ctrl_mem
// Description : Instruction decoder, execute ALU and word-addressed data
//               memory for a single-cycle MIPS-subset datapath.
//   clock, reset            : clock; synchronous active-low reset
//   opCode, funcCode        : instruction[31:26] / instruction[5:0]
//   aluA, aluB, memWData    : ALU operands and store data
//   RegDst..jumpEnable      : decoded control strobes (combinational)
//   aluResult, aluOver      : ALU result (also byte address) and overflow
//   memRData                : read data, zero unless MemRead
// Revision    : 1.0 - initial release
// ============================================================================
module exec_ctrl_mem
    import exec_ctrl_mem_pkg::*;
#(
    parameter int DM_WORDS = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  opCode,
    input  logic [5:0]  funcCode,
    input  logic [31:0] aluA,
    input  logic [31:0] aluB,
    input  logic [31:0] memWData,
    output logic [1:0]  RegDst,
    output logic [1:0]  ALUSrc,
    output logic [1:0]  MemtoReg,
    output logic [1:0]  Branch,
    output logic [2:0]  opALU,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        jumpEnable,
    output logic [31:0] aluResult,
    output logic        aluOver,
    output logic [31:0] memRData
);

    localparam int c_AW = $clog2(DM_WORDS);

    ctrl_t           w_ctrl;
    logic [c_AW-1:0] w_idx;
    logic            w_unused_addr;
    logic [31:0]     r_mem [DM_WORDS];

    // ------------------------------------------------------------------
    // Decoder
    // ------------------------------------------------------------------
    always_comb begin
        w_ctrl = c_CTRL_NOP;
        case (opCode)
            c_OP_RTYPE: begin
                case (funcCode)
                    c_FN_ADDU: w_ctrl = rtype_ctrl(c_ALU_ADD);
                    c_FN_SUBU: w_ctrl = rtype_ctrl(c_ALU_SUB);
                    c_FN_AND:  w_ctrl = rtype_ctrl(c_ALU_AND);
                    c_FN_OR:   w_ctrl = rtype_ctrl(c_ALU_OR);
                    c_FN_SLT:  w_ctrl = rtype_ctrl(c_ALU_SLT);
                    c_FN_JR: begin
                        w_ctrl.branch  = c_BR_JR;
                        w_ctrl.jump_en = 1'b1;
                    end
                    default: ;
                endcase
            end
            c_OP_ORI: begin
                w_ctrl.reg_dst   = c_RD_RT;
                w_ctrl.alu_src   = c_SRC_ZIMM;
                w_ctrl.alu_op    = c_ALU_OR;
                w_ctrl.reg_write = 1'b1;
            end
            c_OP_ADDIU: begin
                w_ctrl.reg_dst   = c_RD_RT;
                w_ctrl.alu_src   = c_SRC_SIMM;
                w_ctrl.alu_op    = c_ALU_ADD;
                w_ctrl.reg_write = 1'b1;
            end
            c_OP_LUI: begin
                w_ctrl.reg_dst   = c_RD_RT;
                w_ctrl.alu_src   = c_SRC_ZIMM;
                w_ctrl.alu_op    = c_ALU_LUI;
                w_ctrl.reg_write = 1'b1;
            end
            c_OP_LW: begin
                w_ctrl.reg_dst    = c_RD_RT;
                w_ctrl.alu_src    = c_SRC_SIMM;
                w_ctrl.alu_op     = c_ALU_ADD;
                w_ctrl.mem_to_reg = c_M2R_MEM;
                w_ctrl.mem_read   = 1'b1;
                w_ctrl.reg_write  = 1'b1;
            end
            c_OP_SW: begin
                w_ctrl.alu_src   = c_SRC_SIMM;
                w_ctrl.alu_op    = c_ALU_ADD;
                w_ctrl.mem_write = 1'b1;
            end
            c_OP_BEQ: begin
                w_ctrl.alu_src = c_SRC_REG;
                w_ctrl.alu_op  = c_ALU_SUB;
                w_ctrl.branch  = c_BR_BEQ;
            end
            c_OP_J: begin
                w_ctrl.branch  = c_BR_JUMP;
                w_ctrl.jump_en = 1'b1;
            end
            c_OP_JAL: begin
                w_ctrl.branch     = c_BR_JUMP;
                w_ctrl.jump_en    = 1'b1;
                w_ctrl.reg_dst    = c_RD_RA;
                w_ctrl.mem_to_reg = c_M2R_PC4;
                w_ctrl.reg_write  = 1'b1;
            end
            default: ;
        endcase
    end

    assign RegDst     = w_ctrl.reg_dst;
    assign ALUSrc     = w_ctrl.alu_src;
    assign MemtoReg   = w_ctrl.mem_to_reg;
    assign Branch     = w_ctrl.branch;
    assign opALU      = w_ctrl.alu_op;
    assign RegWrite   = w_ctrl.reg_write;
    assign MemRead    = w_ctrl.mem_read;
    assign MemWrite   = w_ctrl.mem_write;
    assign jumpEnable = w_ctrl.jump_en;

    // ------------------------------------------------------------------
    // Execute
    // ------------------------------------------------------------------
    exec_alu u_alu (
        .a      (aluA),
        .b      (aluB),
        .op     (w_ctrl.alu_op),
        .result (aluResult),
        .over   (aluOver)
    );

    // ------------------------------------------------------------------
    // Data memory: word index from the byte address; byte offset and the
    // bits above the array size are dropped so addresses wrap.
    // ------------------------------------------------------------------
    assign w_idx         = aluResult[c_AW+1:2];
    assign w_unused_addr = ^{aluResult[31:c_AW+2], aluResult[1:0]};

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < DM_WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_ctrl.mem_write) begin
            r_mem[w_idx] <= memWData;
        end
    end

    // Asynchronous read of the current array contents, so a same-cycle
    // write is only visible after the clock edge.
    assign memRData = w_ctrl.mem_read ? r_mem[w_idx] : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_exec_ctrl_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_exec_ctrl_mem
// Description : Directed self-checking bench for exec_ctrl_mem. Each step
//               drives an instruction, queues the expected observations,
//               then pops and compares them once the outputs settle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exec_ctrl_mem;

    logic        clock;
    logic        reset;
    logic [5:0]  opCode;
    logic [5:0]  funcCode;
    logic [31:0] aluA;
    logic [31:0] aluB;
    logic [31:0] memWData;
    logic [1:0]  RegDst;
    logic [1:0]  ALUSrc;
    logic [1:0]  MemtoReg;
    logic [1:0]  Branch;
    logic [2:0]  opALU;
    logic        RegWrite;
    logic        MemRead;
    logic        MemWrite;
    logic        jumpEnable;
    logic [31:0] aluResult;
    logic        aluOver;
    logic [31:0] memRData;

    exec_ctrl_mem #(.DM_WORDS(1024)) dut (
        .clock      (clock),
        .reset      (reset),
        .opCode     (opCode),
        .funcCode   (funcCode),
        .aluA       (aluA),
        .aluB       (aluB),
        .memWData   (memWData),
        .RegDst     (RegDst),
        .ALUSrc     (ALUSrc),
        .MemtoReg   (MemtoReg),
        .Branch     (Branch),
        .opALU      (opALU),
        .RegWrite   (RegWrite),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .jumpEnable (jumpEnable),
        .aluResult  (aluResult),
        .aluOver    (aluOver),
        .memRData   (memRData)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Observation selectors
    localparam int S_CTRL = 0;
    localparam int S_RES  = 1;
    localparam int S_OVF  = 2;
    localparam int S_RDAT = 3;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } item_t;

    item_t sb[$];
    int    n_checks = 0;
    int    n_errors = 0;

    // Packed control word:
    // {RegDst, ALUSrc, MemtoReg, Branch, opALU, RegWrite, MemRead, MemWrite, jumpEnable}
    function automatic logic [31:0] pk(input logic [1:0] rd, input logic [1:0] src,
                                       input logic [1:0] m2r, input logic [1:0] br,
                                       input logic [2:0] op, input logic rw,
                                       input logic mr, input logic mw, input logic je);
        return {17'd0, rd, src, m2r, br, op, rw, mr, mw, je};
    endfunction

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_CTRL:  return pk(RegDst, ALUSrc, MemtoReg, Branch, opALU,
                               RegWrite, MemRead, MemWrite, jumpEnable);
            S_RES:   return aluResult;
            S_OVF:   return {31'd0, aluOver};
            default: return memRData;
        endcase
    endfunction

    task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] wd);
        @(negedge clock);
        opCode   = op;
        funcCode = fn;
        aluA     = a;
        aluB     = b;
        memWData = wd;
    endtask

    task automatic expect_val(input string tag, input int sel, input logic [31:0] v);
        item_t it;
        it.tag = tag;
        it.sel = sel;
        it.exp = v;
        sb.push_back(it);
    endtask

    task automatic check_all();
        item_t       it;
        logic [31:0] obs;
        #1;
        while (sb.size() > 0) begin
            it  = sb.pop_front();
            obs = observe(it.sel);
            n_checks++;
            assert (obs === it.exp) else begin
                n_errors++;
                $error("FAIL %s: observed %h expected %h", it.tag, obs, it.exp);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b0;
        opCode   = 6'b100011;
        funcCode = 6'd0;
        aluA     = 32'd0;
        aluB     = 32'd0;
        memWData = 32'd0;
        @(negedge clock);
        @(negedge clock);

        // Memory reads zero while reset has been applied
        drive(6'b100011, 6'd0, 32'h10, 32'h4, 32'd0);
        expect_val("reset_rdata", S_RDAT, 32'd0);
        expect_val("reset_lw_ctrl", S_CTRL, pk(2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 1, 1, 0, 0));
        check_all();
        reset = 1'b1;

        // addu
        drive(6'b000000, 6'b100001, 32'd7, 32'd5, 32'd0);
        expect_val("addu_ctrl", S_CTRL, pk(2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0, 0, 0));
        expect_val("addu_res", S_RES, 32'd12);
        expect_val("addu_ovf", S_OVF, 32'd0);
        check_all();

        // subu, negative result without overflow
        drive(6'b000000, 6'b100011, 32'd5, 32'd7, 32'd0);
        expect_val("subu_ctrl", S_CTRL, pk(2'b01, 2'b00, 2'b00, 2'b00, 3'b001, 1, 0, 0, 0));
        expect_val("subu_res", S_RES, 32'hFFFF_FFFE);
        expect_val("subu_ovf", S_OVF, 32'd0);
        check_all();

        // subu with signed overflow
        drive(6'b000000, 6'b100011, 32'h8000_0000, 32'd1, 32'd0);
        expect_val("subu_ovf_res", S_RES, 32'h7FFF_FFFF);
        expect_val("subu_ovf_flag", S_OVF, 32'd1);
        check_all();

        // and / or
        drive(6'b000000, 6'b100100, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0);
        expect_val("and_ctrl", S_CTRL, pk(2'b01, 2'b00, 2'b00, 2'b00, 3'b010, 1, 0, 0, 0));
        expect_val("and_res", S_RES, 32'h00F0_1200);
        check_all();
        drive(6'b000000, 6'b100101, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0);
        expect_val("or_ctrl", S_CTRL, pk(2'b01, 2'b00, 2'b00, 2'b00, 3'b011, 1, 0, 0, 0));
        expect_val("or_res", S_RES, 32'hFFF0_FF34);
        check_all();

        // slt signed: -1 < 1, and 1 < -1 is false
        drive(6'b000000, 6'b101010, 32'hFFFF_FFFF, 32'd1, 32'd0);
        expect_val("slt_ctrl", S_CTRL, pk(2'b01, 2'b00, 2'b00, 2'b00, 3'b100, 1, 0, 0, 0));
        expect_val("slt_true", S_RES, 32'd1);
        check_all();
        drive(6'b000000, 6'b101010, 32'd1, 32'hFFFF_FFFF, 32'd0);
        expect_val("slt_false", S_RES, 32'd0);
        expect_val("slt_ovf", S_OVF, 32'd0);
        check_all();

        // addiu with signed overflow
        drive(6'b001001, 6'b000000, 32'h7FFF_FFFF, 32'd1, 32'd0);
        expect_val("addiu_ctrl", S_CTRL, pk(2'b00, 2'b10, 2'b00, 2'b00, 3'b000, 1, 0, 0, 0));
        expect_val("add_ovf_res", S_RES, 32'h8000_0000);
        expect_val("add_ovf_flag", S_OVF, 32'd1);
        check_all();

        // ori / lui
        drive(6'b001101, 6'b000000, 32'h0000_00F0, 32'h0000_000F, 32'd0);
        expect_val("ori_ctrl", S_CTRL, pk(2'b00, 2'b01, 2'b00, 2'b00, 3'b011, 1, 0, 0, 0));
        expect_val("ori_res", S_RES, 32'h0000_00FF);
        check_all();
        drive(6'b001111, 6'b000000, 32'h5555_5555, 32'h0000_1234, 32'd0);
        expect_val("lui_ctrl", S_CTRL, pk(2'b00, 2'b01, 2'b00, 2'b00, 3'b101, 1, 0, 0, 0));
        expect_val("lui_res", S_RES, 32'h1234_0000);
        check_all();

        // Branches and jumps
        drive(6'b000100, 6'b000000, 32'd3, 32'd3, 32'd0);
        expect_val("beq_ctrl", S_CTRL, pk(2'b00, 2'b00, 2'b00, 2'b01, 3'b001, 0, 0, 0, 0));
        expect_val("beq_res", S_RES, 32'd0);
        check_all();
        drive(6'b000000, 6'b001000, 32'd3, 32'd3, 32'd0);
        expect_val("jr_ctrl", S_CTRL, pk(2'b00, 2'b00, 2'b00, 2'b10, 3'b000, 0, 0, 0, 1));
        check_all();
        drive(6'b000010, 6'b000000, 32'd0, 32'd0, 32'd0);
        expect_val("j_ctrl", S_CTRL, pk(2'b00, 2'b00, 2'b00, 2'b11, 3'b000, 0, 0, 0, 1));
        check_all();
        drive(6'b000011, 6'b101010, 32'd0, 32'd0, 32'd0);
        expect_val("jal_ctrl", S_CTRL, pk(2'b10, 2'b00, 2'b10, 2'b11, 3'b000, 1, 0, 0, 1));
        check_all();

        // Unknown opcode and unknown funct decode to nop
        drive(6'b111111, 6'b100001, 32'd1, 32'd2, 32'd0);
        expect_val("badop_ctrl", S_CTRL, 32'd0);
        check_all();
        drive(6'b000000, 6'b000000, 32'd1, 32'd2, 32'd0);
        expect_val("badfn_ctrl", S_CTRL, 32'd0);
        check_all();

        // sw 0x10+4 -> word 5, read data is zero during the store
        drive(6'b101011, 6'b000000, 32'h10, 32'h4, 32'hDEAD_BEEF);
        expect_val("sw_ctrl", S_CTRL, pk(2'b00, 2'b10, 2'b00, 2'b00, 3'b000, 0, 0, 1, 0));
        expect_val("sw_res", S_RES, 32'h14);
        expect_val("sw_rdata", S_RDAT, 32'd0);
        check_all();
        drive(6'b100011, 6'b000000, 32'h10, 32'h4, 32'd0);
        expect_val("lw_rdata", S_RDAT, 32'hDEAD_BEEF);
        check_all();
        // Byte offset ignored: 0x17 addresses the same word
        drive(6'b100011, 6'b000000, 32'h17, 32'h0, 32'd0);
        expect_val("lw_offset", S_RDAT, 32'hDEAD_BEEF);
        check_all();

        // Word 4 starts empty, then is written through an aliasing address
        drive(6'b100011, 6'b000000, 32'h10, 32'h0, 32'd0);
        expect_val("w4_empty", S_RDAT, 32'd0);
        check_all();
        drive(6'b101011, 6'b000000, 32'h1000, 32'h10, 32'hCAFE_F00D);
        check_all();
        drive(6'b100011, 6'b000000, 32'h10, 32'h0, 32'd0);
        expect_val("alias_rdata", S_RDAT, 32'hCAFE_F00D);
        check_all();

        // Reset with a store pending: memory clears and the store is dropped
        drive(6'b101011, 6'b000000, 32'h10, 32'h4, 32'h1111_1111);
        reset = 1'b0;
        drive(6'b100011, 6'b000000, 32'h10, 32'h4, 32'd0);
        reset = 1'b1;
        expect_val("rst_w5", S_RDAT, 32'd0);
        check_all();
        drive(6'b100011, 6'b000000, 32'h10, 32'h0, 32'd0);
        expect_val("rst_w4", S_RDAT, 32'd0);
        check_all();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
